// File: rtl/appreq_pkg.sv
// Shared types and helpers for the application request arbiter.
package appreq_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StBusy  = 3'd2,
    StDone  = 3'd3,
    StErr   = 3'd4
  } state_e;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rr_pick #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdxW   = 2
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic              gnt_valid_o,
  output logic [IdxW-1:0]   gnt_idx_o
);

  logic [IdxW-1:0] cand;

  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    cand        = '0;
    for (int unsigned off = 0; off < NumReq; off++) begin
      cand = IdxW'((32'(ptr_i) + off) % NumReq);
      if (!gnt_valid_o && req_i[cand]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/appreq_arb.sv
// Multi-channel application request arbiter: round-robin grant, one-cycle start to the
// AHB master engine, then wait for done/error under a watchdog.
module appreq_arb
  import appreq_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned LVL_W     = 5,
  parameter int unsigned THRESH    = 4,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned TO_W      = 8,
  parameter int unsigned TIMEOUT   = 200,
  localparam int unsigned CH_W     = (clog2(NUM_CH) < 1) ? 1 : clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    hreset,
  input  logic [NUM_CH-1:0]       ch_enable_i,
  input  logic [NUM_CH-1:0]       ch_empty_i,
  input  logic [NUM_CH-1:0]       ch_full_i,
  input  logic [NUM_CH*LVL_W-1:0] ch_level_i,
  input  logic                    flush_i,
  input  logic                    done_i,
  input  logic                    error_i,
  output logic                    start_o,
  output logic [CH_W-1:0]         start_ch_o,
  output logic [LVL_W-1:0]        burst_len_o,
  output logic                    busy_o,
  output logic                    timeout_err_o,
  output logic [CH_W-1:0]         err_ch_o
);

  localparam logic [LVL_W-1:0] ThreshL    = LVL_W'(THRESH);
  localparam logic [LVL_W:0]   MaxBurstL  = (LVL_W + 1)'(MAX_BURST);
  localparam logic [TO_W-1:0]  WdExpireL  = TO_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [TO_W-1:0]   wd_q, wd_d;
  logic              start_q, start_d;
  logic [CH_W-1:0]   start_ch_q, start_ch_d;
  logic [LVL_W-1:0]  burst_q, burst_d;
  logic              busy_q, busy_d;
  logic              to_err_q, to_err_d;
  logic [CH_W-1:0]   err_ch_q, err_ch_d;

  logic [LVL_W-1:0]  level [NUM_CH];
  logic [NUM_CH-1:0] elig;
  logic              gnt_valid;
  logic [CH_W-1:0]   gnt_idx;
  logic [LVL_W-1:0]  win_level;
  logic [LVL_W-1:0]  burst_c;
  logic [CH_W-1:0]   ptr_nxt;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      level[i] = ch_level_i[i*LVL_W +: LVL_W];
      elig[i]  = ch_enable_i[i] & ~ch_empty_i[i] & ~ch_full_i[i] &
                 (flush_i | (level[i] >= ThreshL));
    end
  end

  rr_pick #(
    .NumReq (NUM_CH),
    .IdxW   (CH_W)
  ) u_rr_pick (
    .req_i       (elig),
    .ptr_i       (ptr_q),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  // Compare one bit wider so a MAX_BURST beyond the level range never truncates.
  always_comb begin
    win_level = level[gnt_idx];
    burst_c   = ({1'b0, win_level} > MaxBurstL) ? MaxBurstL[LVL_W-1:0] : win_level;
    ptr_nxt   = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    wd_d       = wd_q;
    start_ch_d = start_ch_q;
    burst_d    = burst_q;
    err_ch_d   = err_ch_q;
    to_err_d   = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (gnt_valid) begin
          state_d    = StStart;
          start_ch_d = gnt_idx;
          burst_d    = burst_c;
          ptr_d      = ptr_nxt;
        end else begin
          state_d = StIdle;
        end
      end
      StStart: begin
        wd_d    = '0;
        state_d = StBusy;
      end
      StBusy: begin
        wd_d = wd_q + 1'b1;
        // error beats done, done beats a coincident watchdog expiry
        if (error_i) begin
          state_d = StErr;
        end else if (done_i) begin
          state_d = StDone;
        end else if (wd_q == WdExpireL) begin
          state_d  = StErr;
          to_err_d = 1'b1;
        end
      end
      StErr: begin
        err_ch_d = start_ch_q;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
    start_d = (state_d == StStart);
    busy_d  = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge hreset) begin
    if (hreset) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      wd_q       <= '0;
      start_q    <= 1'b0;
      start_ch_q <= '0;
      burst_q    <= '0;
      busy_q     <= 1'b0;
      to_err_q   <= 1'b0;
      err_ch_q   <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      wd_q       <= wd_d;
      start_q    <= start_d;
      start_ch_q <= start_ch_d;
      burst_q    <= burst_d;
      busy_q     <= busy_d;
      to_err_q   <= to_err_d;
      err_ch_q   <= err_ch_d;
    end
  end

  assign start_o       = start_q;
  assign start_ch_o    = start_ch_q;
  assign burst_len_o   = burst_q;
  assign busy_o        = busy_q;
  assign timeout_err_o = to_err_q;
  assign err_ch_o      = err_ch_q;

endmodule

// File: tb/tb_appreq_arb.sv
// Scoreboard bench for appreq_arb: expected grants/timeouts are queued by the stimulus
// and checked by a monitor whenever the DUT raises start or timeout_err.
module tb_appreq_arb;

  localparam int NUM_CH = 4;
  localparam int LVL_W  = 5;
  localparam int CH_W   = 2;

  logic                    clk = 1'b0;
  logic                    hreset = 1'b1;
  logic [NUM_CH-1:0]       ch_enable = '0;
  logic [NUM_CH-1:0]       ch_empty = '1;
  logic [NUM_CH-1:0]       ch_full = '0;
  logic [NUM_CH*LVL_W-1:0] ch_level = '0;
  logic                    flush = 1'b0;
  logic                    done = 1'b0;
  logic                    error = 1'b0;
  logic                    start_o;
  logic [CH_W-1:0]         start_ch_o;
  logic [LVL_W-1:0]        burst_len_o;
  logic                    busy_o;
  logic                    timeout_err_o;
  logic [CH_W-1:0]         err_ch_o;

  typedef struct {
    int ch;
    int len;
  } grant_t;

  grant_t exp_q[$];
  int     to_q[$];
  int     n_vec = 0;
  int     n_bad = 0;

  always #5 clk = ~clk;

  appreq_arb u_dut (
    .clk           (clk),
    .hreset        (hreset),
    .ch_enable_i   (ch_enable),
    .ch_empty_i    (ch_empty),
    .ch_full_i     (ch_full),
    .ch_level_i    (ch_level),
    .flush_i       (flush),
    .done_i        (done),
    .error_i       (error),
    .start_o       (start_o),
    .start_ch_o    (start_ch_o),
    .burst_len_o   (burst_len_o),
    .busy_o        (busy_o),
    .timeout_err_o (timeout_err_o),
    .err_ch_o      (err_ch_o)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_ch(input int i, input bit en, input int lvl);
    logic [31:0] l;
    l = lvl;
    ch_enable[i] = en;
    ch_empty[i]  = (lvl == 0);
    ch_level[i*LVL_W +: LVL_W] = l[LVL_W-1:0];
  endtask

  task automatic clear_all();
    for (int i = 0; i < NUM_CH; i++) set_ch(i, 1'b0, 0);
    ch_full = '0;
  endtask

  task automatic push_grant(input int ch, input int len);
    grant_t g;
    g.ch  = ch;
    g.len = len;
    exp_q.push_back(g);
  endtask

  // Called in the START cycle: return done after busy_cycles BUSY cycles, end in IDLE.
  task automatic xfer_done(input int busy_cycles);
    repeat (busy_cycles) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a start or timeout.
  always @(negedge clk) begin
    if (!hreset && start_o) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_start: got ch=%0d len=%0d, expected no start",
                 start_ch_o, burst_len_o);
      end else begin
        grant_t g;
        g = exp_q.pop_front();
        chk("grant_ch", 32'(start_ch_o), g.ch);
        chk("grant_len", 32'(burst_len_o), g.len);
      end
    end
    if (!hreset && timeout_err_o) begin
      if (to_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_timeout: got ch=%0d, expected no timeout", start_ch_o);
      end else begin
        chk("timeout_ch", 32'(start_ch_o), to_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    // Reset state
    repeat (2) tick();
    chk("rst_start", 32'(start_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_start_ch", 32'(start_ch_o), 0);
    chk("rst_burst", 32'(burst_len_o), 0);
    chk("rst_timeout", 32'(timeout_err_o), 0);
    chk("rst_err_ch", 32'(err_ch_o), 0);
    hreset = 1'b0;
    tick();

    // Single channel, done after 5 BUSY cycles
    set_ch(0, 1'b1, 6);
    push_grant(0, 6);
    tick();
    chk("s1_start_latency", 32'(start_o), 1);
    chk("s1_busy_start", 32'(busy_o), 1);
    set_ch(0, 1'b0, 0);
    repeat (5) tick();
    chk("s1_busy_in_busy", 32'(busy_o), 1);
    chk("s1_start_one_cycle", 32'(start_o), 0);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("s1_busy_done", 32'(busy_o), 1);
    tick();
    chk("s1_idle", 32'(busy_o), 0);

    // Round robin from pointer 0, back-to-back every 3 cycles
    hreset = 1'b1;
    tick();
    hreset = 1'b0;
    for (int i = 0; i < NUM_CH; i++) set_ch(i, 1'b1, 8);
    push_grant(0, 8);
    push_grant(1, 8);
    push_grant(2, 8);
    push_grant(3, 8);
    push_grant(0, 8);
    tick();
    for (int g = 0; g < 5; g++) begin
      chk("rr_start_spacing", 32'(start_o), 1);
      if (g == 4) clear_all();
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      chk("rr_no_start_in_done", 32'(start_o), 0);
      tick();
    end
    chk("rr_idle", 32'(busy_o), 0);

    // Threshold then flush; clamp to MAX_BURST
    set_ch(2, 1'b1, 2);
    repeat (4) tick();
    chk("thr_below_no_busy", 32'(busy_o), 0);
    flush = 1'b1;
    push_grant(2, 2);
    tick();
    chk("thr_flush_start", 32'(start_o), 1);
    flush = 1'b0;
    set_ch(2, 1'b0, 0);
    xfer_done(1);
    set_ch(2, 1'b1, 20);
    push_grant(2, 16);
    tick();
    chk("thr_clamp_start", 32'(start_o), 1);
    set_ch(2, 1'b0, 0);
    xfer_done(1);

    // Watchdog expiry after 200 BUSY cycles
    set_ch(1, 1'b1, 5);
    push_grant(1, 5);
    to_q.push_back(1);
    tick();
    set_ch(1, 1'b0, 0);
    cnt = 0;
    while (!timeout_err_o && cnt < 300) begin
      tick();
      cnt++;
    end
    chk("to_cycles", cnt, 201);
    chk("to_busy_in_err", 32'(busy_o), 1);
    tick();
    chk("to_pulse_width", 32'(timeout_err_o), 0);
    chk("to_err_ch", 32'(err_ch_o), 1);
    chk("to_idle", 32'(busy_o), 0);

    // Done on the expiry cycle wins
    set_ch(1, 1'b1, 5);
    push_grant(1, 5);
    tick();
    set_ch(1, 1'b0, 0);
    repeat (200) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("to_done_wins", 32'(timeout_err_o), 0);
    chk("to_done_busy", 32'(busy_o), 1);
    tick();
    chk("to_done_idle", 32'(busy_o), 0);

    // Error together with done: error wins, err_ch updated
    set_ch(0, 1'b1, 7);
    push_grant(0, 7);
    tick();
    set_ch(0, 1'b0, 0);
    tick();
    error = 1'b1;
    done  = 1'b1;
    tick();
    error = 1'b0;
    done  = 1'b0;
    chk("err_busy_in_err", 32'(busy_o), 1);
    tick();
    chk("err_err_ch", 32'(err_ch_o), 0);
    chk("err_idle", 32'(busy_o), 0);

    // Back-pressure on ch3
    set_ch(3, 1'b1, 8);
    ch_full[3] = 1'b1;
    repeat (5) tick();
    chk("bp_blocked", 32'(busy_o), 0);
    ch_full[3] = 1'b0;
    push_grant(3, 8);
    tick();
    chk("bp_released", 32'(start_o), 1);
    set_ch(3, 1'b0, 0);
    xfer_done(1);

    // Reset mid-BUSY restarts the search at channel 0
    set_ch(1, 1'b1, 8);
    push_grant(1, 8);
    tick();
    set_ch(1, 1'b0, 0);
    repeat (2) tick();
    hreset = 1'b1;
    #1;
    chk("rst_mid_busy", 32'(busy_o), 0);
    chk("rst_mid_start_ch", 32'(start_ch_o), 0);
    chk("rst_mid_burst", 32'(burst_len_o), 0);
    set_ch(0, 1'b1, 8);
    set_ch(2, 1'b1, 8);
    push_grant(0, 8);
    tick();
    hreset = 1'b0;
    tick();
    chk("rst_regrant", 32'(start_o), 1);
    clear_all();
    xfer_done(1);

    repeat (3) tick();
    chk("sb_grants_drained", exp_q.size(), 0);
    chk("sb_timeouts_drained", to_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/appreq_arb.md
Name: appreq_arb

Overview:
Multi-channel successor to the single-channel application request sequencer. It watches NUM_CH application FIFOs and picks one eligible channel per transfer using round-robin, with a level threshold and a flush override. It issues a one-cycle start with channel index and burst length to the AHB master engine, then waits for done or error, with a watchdog timeout. It sits between the per-channel application FIFOs and the AHB master interface.

Parameters:
NUM_CH, 4, number of request channels (2..16); localparam CH_W = clog2(NUM_CH), minimum 1
LVL_W, 5, width of each FIFO level field
THRESH, 4, minimum FIFO level for eligibility when not flushing (1..2^LVL_W-1)
MAX_BURST, 16, maximum burst_len issued
TO_W, 8, watchdog counter width
TIMEOUT, 200, BUSY cycles before a timeout (1..2^TO_W-1)

Ports:
clk  in  1  clock
hreset  in  1  reset
ch_enable  in  NUM_CH  per-channel enable
ch_empty  in  NUM_CH  per-channel FIFO empty
ch_full  in  NUM_CH  per-channel destination full (back-pressure)
ch_level  in  NUM_CH*LVL_W  per-channel FIFO level; channel i occupies bits [i*LVL_W +: LVL_W]
flush  in  1  ignore THRESH (drain partial data)
done  in  1  transfer complete, 1-cycle pulse from the master engine
error  in  1  transfer error, 1-cycle pulse from the master engine
start  out  1  one-cycle transfer request
start_ch  out  CH_W  granted channel, valid while start=1 and held until the next grant
burst_len  out  LVL_W  beats to transfer, held with start_ch
busy  out  1  high in START, BUSY, DONE and ERR
timeout_err  out  1  one-cycle pulse on watchdog expiry
err_ch  out  CH_W  channel of the last error or timeout

Behaviour:
- Reset is hreset, asynchronous, active-high; clock clk. All outputs are registered. Reset values: state IDLE, all outputs 0, round-robin pointer 0, watchdog 0.
- Eligible(i) = ch_enable[i] & !ch_empty[i] & !ch_full[i] & (flush | level[i] >= THRESH).
- Arbitration runs combinationally in IDLE and DONE. Search starts at pointer and wraps modulo NUM_CH. The first eligible channel wins. On a grant, pointer <= winner+1, wrapping NUM_CH-1 to 0.
- burst_len = min(level[winner], MAX_BURST), computed with LVL_W+1-bit compare, no truncation.
- States: IDLE, START, BUSY, DONE, ERR.
  - IDLE: if any channel is eligible, go to START, latching start_ch and burst_len; otherwise stay in IDLE.
  - START: start=1 for exactly one cycle. Watchdog cleared. Unconditionally go to BUSY. done and error are ignored here.
  - BUSY: watchdog increments each cycle. Checks in priority order:
    - error: go to ERR
    - done: go to DONE
    - watchdog == TIMEOUT-1: go to ERR, with timeout_err pulsed in the ERR cycle
  - DONE: re-arbitrate exactly as IDLE. If a channel is eligible, go straight to START (back-to-back), otherwise go to IDLE.
  - ERR: err_ch <= start_ch. Go to IDLE.
- Latency: eligibility sampled at edge k gives start=1 in cycle k+1. Minimum request-to-request spacing is 3 cycles (START, BUSY, DONE).
- Simultaneous done and watchdog expiry: done wins, no timeout_err. Simultaneous done and error: error wins.
- A channel dropping eligibility after grant does not cancel the transfer.
- Channel masking: disabled channels are skipped but do not move the pointer.
- Starvation-free: every continuously eligible channel is granted within NUM_CH grants.
- hreset mid-transfer: immediate return to IDLE, outputs cleared, pointer 0.

Decomposition:
- Shared package appreq_pkg: state encoding constants (IDLE=0, START=1, BUSY=2, DONE=3, ERR=4, 3-bit), plus a clog2 function.
- Sub-module rr_pick: a combinational round-robin priority picker taking req[NUM_CH] and ptr, and producing gnt_valid and gnt_idx. It is reusable by other arbiters in the design.

Test Plan:
- Single channel: ch0 level=6, others empty -> start in the cycle after eligibility, start_ch=0, burst_len=6; done after 5 BUSY cycles -> DONE, then IDLE.
- Round-robin: all 4 channels at level=8, done returned each time -> grant order 0,1,2,3,0 with back-to-back starts 3 cycles apart.
- Threshold and flush: ch2 level=2, THRESH=4 -> no start; assert flush -> start_ch=2, burst_len=2. Level=20 -> burst_len=16.
- Timeout: grant ch1, never assert done -> timeout_err pulses after 200 BUSY cycles, err_ch=1, then IDLE. Done on the expiry cycle -> no timeout_err.
- Error and back-pressure: error in BUSY -> ERR, err_ch set. ch_full[3]=1 with ch3 eligible otherwise -> ch3 never granted; releasing it -> ch3 granted.
- Reset mid-BUSY: hreset asynchronously -> busy=0, start=0, state IDLE immediately; the next grant begins searching from channel 0.
